bcd_seq_conv: RTL

Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It is the next generation of the RPM display converter.
- Generalised in input width and digit count.
- Adds a valid/ready input handshake, a one-cycle result strobe, overflow saturation, leading-zero blanking and decimal-point placement.
- Sits between the RPM measurement/scaling logic and the seven-segment digit multiplexer.

---
 rtl/bcd_seq_conv_pkg.sv | 20 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_seq_conv.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bcd_seq_conv_pkg.sv
// Shared constants for the binary-to-BCD display path: FSM encoding,
// blank digit code and the default geometry used by the RPM path and
// the seven-segment digit multiplexer.
package bcd_seq_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [3:0] BCD_BLANK       = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH  = 4'd5;
  localparam logic [3:0] BCD_ADJ_OFFSET  = 4'd3;

  localparam int DEF_BIN_WIDTH = 16;
  localparam int DEF_DIGITS    = 4;
  localparam int DEF_DP_WIDTH  = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction cell: a BCD digit of 5 or more gets 3
// added so that the following left shift carries into the next digit.
module bcd_digit_adj
  import bcd_seq_conv_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Conditional add-3 applied before every shift
  always_comb begin
    q = d;
    if (d >= BCD_ADJ_THRESH) q = d + BCD_ADJ_OFFSET;
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready input, one-cycle result strobe, overflow saturation,
// leading-zero blanking and decimal-point placement.
module bcd_seq_conv
  import bcd_seq_conv_pkg::*;
#(
  parameter int BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int DIGITS    = DEF_DIGITS,
  parameter int DP_WIDTH  = DEF_DP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  input  logic [DP_WIDTH-1:0]    dp_pos,
  input  logic                   dp_en,
  output logic                   out_valid,
  output logic [4*DIGITS-1:0]    digits,
  output logic [DIGITS-1:0]      dp,
  output logic                   overflow
);

  localparam int DW    = 4 * DIGITS;
  localparam int SR_W  = DW + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Idle display: a single "0" in digit 0, everything above blanked
  localparam logic [DW-1:0]    RST_DIGITS = {DW{1'b1}} << 4;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIN_WIDTH - 1);

  state_t               state;
  logic [BIN_WIDTH-1:0] p;
  logic [DW-1:0]        dec;
  logic [DW-1:0]        dec_adj;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic [DP_WIDTH-1:0]  dp_pos_q;
  logic                 dp_en_q;
  logic [SR_W-1:0]      sr_shl;
  logic                 carry_out;
  logic                 dp_en_eff;

  // Force every digit to 9 when the value did not fit
  function automatic logic [DW-1:0] saturate(input logic sat,
                                             input logic [DW-1:0] val);
    return sat ? {DIGITS{4'd9}} : val;
  endfunction

  // Blank leading zero digits, keeping digit 0 and anything at or below
  // an active decimal point visible
  function automatic logic [DW-1:0] blank_lz(input logic [DW-1:0] val,
                                             input logic en,
                                             input logic [DP_WIDTH-1:0] pos);
    logic [DW-1:0] res;
    logic          zero_above;
    res        = val;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (val[4*k +: 4] == 4'd0);
      if (zero_above && (!en || (k > int'(pos)))) res[4*k +: 4] = BCD_BLANK;
    end
    return res;
  endfunction

  // One-hot decimal point enable for the selected digit
  function automatic logic [DIGITS-1:0] dp_onehot(input logic en,
                                                  input logic [DP_WIDTH-1:0] pos);
    logic [DIGITS-1:0] res;
    res = '0;
    for (int k = 0; k < DIGITS; k++) res[k] = en && (int'(pos) == k);
    return res;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (dec[4*g +: 4]),
      .q (dec_adj[4*g +: 4])
    );
  end

  // A set bit leaving the top digit means the value reached 10**DIGITS
  assign sr_shl    = {dec_adj, p} << 1;
  assign carry_out = dec_adj[DW-1];

  // An out-of-range decimal point position behaves as if disabled
  assign dp_en_eff = dp_en_q && (int'(dp_pos_q) < DIGITS);

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      digits    <= RST_DIGITS;
      dp        <= '0;
      overflow  <= 1'b0;
      p         <= '0;
      dec       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      dp_pos_q  <= '0;
      dp_en_q   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            p        <= bin_in;
            dec      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            dp_pos_q <= dp_pos;
            dp_en_q  <= dp_en;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {dec, p} <= sr_shl;
          if (carry_out) ovf <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIN;
        end
        FIN: begin
          digits    <= blank_lz(saturate(ovf, dec), dp_en_eff, dp_pos_q);
          dp        <= dp_onehot(dp_en_eff, dp_pos_q);
          overflow  <= ovf;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
